// File: rtl/dct8x8_buf_feeder.sv
// Front end for the 8x8 DCT transpose buffer: packs pairs of image rows into
// 16-sample beats (four per block), tracks block framing and the per-block
// write-orientation flag, and flags upstream row-count errors.
module dct8x8_buf_feeder #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       feed_vld_i,
  input  logic [DATA_WIDTH*8-1:0]    feed_data_i,
  input  logic                       feed_last_i,
  output logic                       feed_rdy_i,
  output logic                       dct8x8_buf_vld_o,
  output logic [DATA_WIDTH*16-1:0]   dct8x8_buf_data_o,
  input  logic                       dct8x8_buf_rdy_o,
  output logic                       dct8x8_buf_wr_row_flag,
  output logic                       feed_blk_last_o,
  output logic                       feed_err_o
);

  logic                      half_vld_q, half_vld_d;
  logic [DATA_WIDTH*8-1:0]   low_half_q, low_half_d;
  logic                      out_vld_q, out_vld_d;
  logic [DATA_WIDTH*16-1:0]  data_q, data_d;
  logic                      blk_last_q, blk_last_d;
  logic [2:0]                row_cnt_q, row_cnt_d;
  logic [1:0]                beat_cnt_q, beat_cnt_d;
  logic                      wr_row_flag_q, wr_row_flag_d;
  logic                      err_q, err_d;
  logic                      in_xfer, out_xfer;

  // Ready and handshake decode; ready never depends on feed_vld_i.
  always_comb begin
    feed_rdy_i = ~half_vld_q | ~out_vld_q | dct8x8_buf_rdy_o;
    in_xfer    = feed_vld_i & feed_rdy_i;
    out_xfer   = out_vld_q & dct8x8_buf_rdy_o;
  end

  // Next-state logic for row pairing, beat/block framing and error tracking.
  always_comb begin
    half_vld_d    = half_vld_q;
    low_half_d    = low_half_q;
    out_vld_d     = out_vld_q;
    data_d        = data_q;
    blk_last_d    = blk_last_q;
    row_cnt_d     = row_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    wr_row_flag_d = wr_row_flag_q;
    err_d         = err_q;

    if (out_xfer) begin
      out_vld_d  = 1'b0;
      beat_cnt_d = beat_cnt_q + 2'd1;
      // Orientation flips only once the block's final beat has left.
      if (blk_last_q) begin
        wr_row_flag_d = ~wr_row_flag_q;
      end
    end

    if (in_xfer) begin
      row_cnt_d = row_cnt_q + 3'd1;
      if (feed_last_i != (row_cnt_q == 3'd7)) begin
        err_d = 1'b1;
      end
      if (half_vld_q) begin
        data_d    = {feed_data_i, low_half_q};
        out_vld_d = 1'b1;
        half_vld_d = 1'b0;
        // beat_cnt_d already counts a beat leaving this same cycle, so it is
        // the in-block index of the beat being formed.
        blk_last_d = (beat_cnt_d == 2'd3);
      end else begin
        low_half_d = feed_data_i;
        half_vld_d = 1'b1;
      end
    end
  end

  // State registers; async reset discards any partially built block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_vld_q    <= 1'b0;
      low_half_q    <= '0;
      out_vld_q     <= 1'b0;
      data_q        <= '0;
      blk_last_q    <= 1'b0;
      row_cnt_q     <= 3'd0;
      beat_cnt_q    <= 2'd0;
      wr_row_flag_q <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      half_vld_q    <= half_vld_d;
      low_half_q    <= low_half_d;
      out_vld_q     <= out_vld_d;
      data_q        <= data_d;
      blk_last_q    <= blk_last_d;
      row_cnt_q     <= row_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      wr_row_flag_q <= wr_row_flag_d;
      err_q         <= err_d;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    dct8x8_buf_vld_o       = out_vld_q;
    dct8x8_buf_data_o      = data_q;
    dct8x8_buf_wr_row_flag = wr_row_flag_q;
    feed_blk_last_o        = blk_last_q;
    feed_err_o             = err_q;
  end

endmodule

// File: tb/tb_dct8x8_buf_feeder.sv
// Self-checking bench for dct8x8_buf_feeder. A row-level reference model
// (queue of accepted rows, count of beats taken) predicts every output.
module tb_dct8x8_buf_feeder;

  localparam int unsigned DW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              feed_vld_i = 1'b0;
  logic [DW*8-1:0]   feed_data_i = '0;
  logic              feed_last_i = 1'b0;
  logic              feed_rdy_i;
  logic              dct8x8_buf_vld_o;
  logic [DW*16-1:0]  dct8x8_buf_data_o;
  logic              dct8x8_buf_rdy_o = 1'b0;
  logic              dct8x8_buf_wr_row_flag;
  logic              feed_blk_last_o;
  logic              feed_err_o;

  dct8x8_buf_feeder #(.DATA_WIDTH(DW)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .feed_vld_i             (feed_vld_i),
    .feed_data_i            (feed_data_i),
    .feed_last_i            (feed_last_i),
    .feed_rdy_i             (feed_rdy_i),
    .dct8x8_buf_vld_o       (dct8x8_buf_vld_o),
    .dct8x8_buf_data_o      (dct8x8_buf_data_o),
    .dct8x8_buf_rdy_o       (dct8x8_buf_rdy_o),
    .dct8x8_buf_wr_row_flag (dct8x8_buf_wr_row_flag),
    .feed_blk_last_o        (feed_blk_last_o),
    .feed_err_o             (feed_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state since the last reset.
  logic [DW*8-1:0] rows[$];
  int  acc = 0;       // rows accepted
  int  xfer = 0;      // beats taken by the buffer
  bit  err_exp = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*8-1:0] seq_row(input int r);
    logic [DW*8-1:0] v;
    for (int c = 0; c < 8; c++) v[c*DW +: DW] = DW'(r * 8 + c);
    return v;
  endfunction

  // One clock: drive inputs just after negedge, check before posedge, advance model.
  task automatic step(input bit v, input logic [DW*8-1:0] d, input bit l, input bit r,
                      output bit accepted);
    int  pending;
    bit  exp_rdy;
    bit  exp_vld;
    feed_vld_i       = v;
    feed_data_i      = d;
    feed_last_i      = l;
    dct8x8_buf_rdy_o = r;
    #4;
    pending = acc - 2 * xfer;
    exp_vld = (pending >= 2);
    exp_rdy = (pending < 3) || r;
    chk("err", feed_err_o, err_exp);
    chk("out_vld", dct8x8_buf_vld_o, exp_vld);
    chk("feed_rdy", feed_rdy_i, exp_rdy);
    chk("wr_row_flag", dct8x8_buf_wr_row_flag, ((xfer / 4) % 2) == 0);
    if (exp_vld) begin
      chk("beat_data", dct8x8_buf_data_o, {rows[2*xfer+1], rows[2*xfer]});
      chk("blk_last", feed_blk_last_o, (xfer % 4) == 3);
    end
    accepted = v && exp_rdy;
    if (exp_vld && r) xfer++;
    if (accepted) begin
      if (l != ((acc % 8) == 7)) err_exp = 1'b1;
      rows.push_back(d);
      acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer rows start..n-1; bad_last >= 0 moves feed_last to that row index instead.
  task automatic send_rows(input int start, input int n, input int vpct, input int rpct,
                           input bit seq, input int bad_last);
    int idx = start;
    int cyc = 0;
    bit a;
    bit v;
    bit r;
    bit l;
    logic [DW*8-1:0] d;
    while (idx < n && cyc < (n - start) * 40 + 20) begin
      v = ($urandom_range(99) < vpct);
      r = ($urandom_range(99) < rpct);
      l = (bad_last >= 0) ? (idx == bad_last) : ((idx % 8) == 7);
      d = seq ? seq_row(idx % 8) : {$urandom(), $urandom()};
      step(v, d, l, r, a);
      if (a) idx++;
      cyc++;
    end
    chk("send_budget", idx, n);
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 20 && (acc - 2 * xfer) >= 2; i++) step(1'b0, '0, 1'b0, 1'b1, a);
    step(1'b0, '0, 1'b0, 1'b1, a);
  endtask

  task automatic do_reset();
    feed_vld_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", dct8x8_buf_vld_o, 1'b0);
    chk("rst_data", dct8x8_buf_data_o, '0);
    chk("rst_flag", dct8x8_buf_wr_row_flag, 1'b1);
    chk("rst_last", feed_blk_last_o, 1'b0);
    chk("rst_err", feed_err_o, 1'b0);
    chk("rst_rdy", feed_rdy_i, 1'b1);
    rows.delete();
    acc = 0;
    xfer = 0;
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit a;
    int idx;
    // Power-on reset.
    @(negedge clk);
    do_reset();

    // One sequential block, buffer always ready.
    send_rows(0, 8, 100, 100, 1'b1, -1);
    drain();
    chk("beats_blk1", xfer, 4);

    // Two back-to-back blocks at full rate.
    send_rows(0, 16, 100, 100, 1'b1, -1);
    drain();
    chk("beats_blk2", xfer, 12);

    // Buffer stall after beat0 of a block.
    step(1'b1, seq_row(0), 1'b0, 1'b1, a);
    step(1'b1, seq_row(1), 1'b0, 1'b1, a);
    idx = 2;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq_row(idx), 1'b0, 1'b0, a);
      if (a) idx++;
    end
    chk("stall_rows_taken", idx, 3);
    send_rows(3, 8, 100, 100, 1'b1, -1);
    drain();
    chk("beats_stall", xfer, 16);

    // Random valid/ready over 16 blocks.
    send_rows(0, 128, 50, 50, 1'b0, -1);
    drain();
    chk("beats_random", xfer, 80);
    chk("err_clean", feed_err_o, 1'b0);

    // Framing error: last on row 5, then a correct block keeps err high.
    send_rows(0, 8, 100, 100, 1'b1, 5);
    drain();
    chk("err_set", feed_err_o, 1'b1);
    send_rows(0, 8, 100, 100, 1'b0, -1);
    drain();
    chk("err_sticky", feed_err_o, 1'b1);

    // Reset mid-block, then a fresh block.
    send_rows(0, 3, 100, 100, 1'b1, -1);
    do_reset();
    send_rows(0, 8, 100, 100, 1'b1, -1);
    drain();
    chk("beats_after_rst", xfer, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
